// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU constants for the instruction memory and its loader
//  Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam int IMEM_DEPTH = 128;
    localparam int WORD_W     = 32;

    localparam logic [1:0] LD_IDLE   = 2'd0;
    localparam logic [1:0] LD_HEADER = 2'd1;
    localparam logic [1:0] LD_LOAD   = 2'd2;
    localparam logic [1:0] LD_DONE   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte stream input and instruction memory write port bundle
//  Revision    : 1.0
// ============================================================================
interface imem_loader_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    // Upstream byte source plus memory write port observer
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    // Loader side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_assembler
//  Description : Big-endian 4-byte shift register with a wrapping byte counter
//  Revision    : 1.0
// ============================================================================
module byte_assembler
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_clear,
    input  wire logic              i_shift_en,
    input  wire logic [7:0]        i_byte,
    output logic                   o_word_ready,
    output logic [WORD_W-1:0]      o_word
);

    logic [WORD_W-1:0] r_shift;
    logic [1:0]        r_cnt;

    // o_word already includes the byte being accepted, so the word is usable
    // on the same edge that completes it.
    assign o_word       = {r_shift[WORD_W-9:0], i_byte};
    assign o_word_ready = i_shift_en && (r_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (i_shift_en) begin
            r_shift <= o_word;
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Streams a length-prefixed program image into instruction
//                memory and holds the CPU in reset until it is loaded
//  Revision    : 1.0
// ============================================================================
module imem_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 32
)(
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      start,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           overflow
);

    localparam int                IDX_W      = $clog2(DEPTH) + 1;
    localparam int                PAD_W      = ADDR_W - IDX_W - 2;
    localparam logic [WORD_W-1:0] C_DEPTH_W  = WORD_W'(DEPTH);
    localparam logic [IDX_W-1:0]  C_DEPTH_I  = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]  C_ONE_I    = IDX_W'(1);

    logic [1:0]         r_state;
    logic               r_in_ready;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [WORD_W-1:0]  r_wr_data;
    logic               r_cpu_hold;
    logic               r_done;
    logic               r_overflow;
    logic [IDX_W-1:0]   r_word_idx;
    logic [IDX_W-1:0]   r_target;

    logic               w_shift_en;
    logic               w_start_ok;
    logic               w_word_ready;
    logic [WORD_W-1:0]  w_word;

    assign w_shift_en = bus.in_valid && r_in_ready;
    assign w_start_ok = start && ((r_state == LD_IDLE) || (r_state == LD_DONE));

    byte_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_shift_en   (w_shift_en),
        .i_byte       (bus.in_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= LD_IDLE;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_word_idx <= '0;
            r_target   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                LD_IDLE, LD_DONE: begin
                    if (start) begin
                        r_state    <= LD_HEADER;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_overflow <= 1'b0;
                        r_word_idx <= '0;
                    end
                end
                LD_HEADER: begin
                    if (w_word_ready) begin
                        if (w_word == '0) begin
                            r_state    <= LD_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= LD_LOAD;
                            if (w_word > C_DEPTH_W) begin
                                r_overflow <= 1'b1;
                                r_target   <= C_DEPTH_I;
                            end else begin
                                r_target   <= w_word[IDX_W-1:0];
                            end
                        end
                    end
                end
                LD_LOAD: begin
                    if (r_wr_en) begin
                        // Index stays on the last word so it never reaches DEPTH.
                        if (r_word_idx == r_target - C_ONE_I) begin
                            r_state    <= LD_DONE;
                            r_in_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_word_idx <= r_word_idx + C_ONE_I;
                        end
                    end else if (w_word_ready) begin
                        r_wr_en    <= 1'b1;
                        r_wr_data  <= w_word;
                        r_wr_addr  <= {{PAD_W{1'b0}}, r_word_idx, 2'b00};
                        r_in_ready <= 1'b0;
                    end
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Randomized self-checking bench for imem_loader
//  Revision    : 1.0
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH = 128;

    logic clk;
    logic reset;
    logic start;
    logic cpu_hold;
    logic done;
    logic overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wq[$];
    logic [31:0] pay[$];

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every memory write is recorded; the loader must stall the stream on it.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq.push_back({bus.wr_addr, bus.wr_data});
            check("in_ready_on_wr", 64'(bus.in_ready), 64'(0));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int waited;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            check("byte_accept_timeout", 64'(waited), 64'(0));
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_cpu_hold", 64'(cpu_hold), 64'(1));
        check("start_done_clr", 64'(done), 64'(0));
        check("start_in_ready", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", 64'(c < 2000), 64'(1));
    endtask

    task automatic send_header(input int n, input int maxgap);
        logic [31:0] nh;
        nh = n;
        for (int k = 0; k < 4; k++) send_byte(nh[31-8*k -: 8], maxgap);
    endtask

    // Loads pay[] behind a header of n; model: min(n,DEPTH) writes at 4*i.
    task automatic run_load(input int n, input int maxgap, input bit pulse_start);
        int nw;
        logic [31:0] w;
        nw = (n > DEPTH) ? DEPTH : n;
        wq.delete();
        do_start();
        send_header(n, maxgap);
        for (int i = 0; i < nw; i++) begin
            w = pay[i];
            for (int k = 0; k < 4; k++) begin
                if (pulse_start && k == 1) start = 1'b1;
                send_byte(w[31-8*k -: 8], maxgap);
                start = 1'b0;
            end
        end
        wait_done();
        @(negedge clk);
        check("n_writes", 64'(wq.size()), 64'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++) begin
            check("wr_addr", 64'(wq[i][63:32]), 64'(i * 4));
            check("wr_data", 64'(wq[i][31:0]), 64'(pay[i]));
        end
        check("end_done", 64'(done), 64'(1));
        check("end_cpu_hold", 64'(cpu_hold), 64'(0));
        check("end_in_ready", 64'(bus.in_ready), 64'(0));
        check("end_overflow", 64'(overflow), 64'(n > DEPTH));
    endtask

    initial begin
        logic [31:0] w;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        check("rst_wr_data", 64'(bus.wr_data), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        @(posedge clk);
        #1;

        // Directed two-word image
        pay.delete();
        pay.push_back(32'h20080020);
        pay.push_back(32'h20090037);
        run_load(2, 0, 1'b0);

        // Empty image
        pay.delete();
        run_load(0, 0, 1'b0);

        // Oversized header clamps to DEPTH words
        pay.delete();
        for (int i = 0; i < DEPTH; i++) pay.push_back($urandom);
        run_load(200, 0, 1'b0);
        check("ovf_last_addr", 64'(wq[wq.size()-1][63:32]), 64'(32'h1FC));
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ovf_no_accept", 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Bursty stream
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back($urandom);
        run_load(3, 3, 1'b0);

        // Reset after two payload bytes of word 1
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back($urandom);
        wq.delete();
        do_start();
        send_header(3, 1);
        w = pay[0];
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], 1);
        w = pay[1];
        for (int k = 0; k < 2; k++) send_byte(w[31-8*k -: 8], 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("mid_rst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("mid_rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        check("mid_rst_nwrites", 64'(wq.size()), 64'(1));
        if (wq.size() > 0) check("mid_rst_word0", wq[0], {32'h0, pay[0]});
        @(posedge clk);
        #1;

        // Fresh load after the abort starts again at address 0
        pay.delete();
        for (int i = 0; i < 2; i++) pay.push_back($urandom);
        run_load(2, 2, 1'b0);

        // Reload from DONE with start pulses scattered through LOAD
        pay.delete();
        for (int i = 0; i < 4; i++) pay.push_back($urandom);
        run_load(4, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the 128-word instruction memory.
- Receives a byte stream over a valid/ready handshake (from a UART RX or a testbench driver) and assembles it big-endian into 32-bit instruction words.
- Writes each word into the instruction memory write port at byte addresses 0, 4, 8, ...
- Holds the CPU in reset until the program image has been loaded.

Parameters:
- DEPTH, 128, instruction memory size in words.
- ADDR_W, 32, width of the byte address driven to memory; matches the CPU PC width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a new load; ignored unless in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  byte address of the word (word index * 4).
- wr_data  output  32  instruction word.
- cpu_hold  output  1  keeps the CPU reset asserted while loading.
- done  output  1  load finished; level signal.
- overflow  output  1  header count exceeded DEPTH; sticky until next start or reset.

Behaviour:
- Byte transfer: a byte is transferred on any rising edge where in_valid && in_ready.
- Byte order: the first byte of each group of 4 is bits [31:24] (big-endian), matching the assembler dump order.
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, overflow=0.
  - The byte counter, word counter and word target also reset to 0.
- States:
  - IDLE: in_ready=0, cpu_hold=1. On start, go to HEADER and clear the byte counter, word counter, overflow and done.
  - HEADER: in_ready=1. Collect 4 bytes as the word count N (big-endian).
    - On the 4th accepted byte, if N=0 go to DONE.
    - If N>DEPTH, set overflow=1, clamp the target to DEPTH and go to LOAD.
    - Otherwise the target is N; go to LOAD.
  - LOAD: in_ready=1 except during the single cycle in which wr_en is asserted (in_ready=0 that cycle).
    - Each accepted byte shifts into a 32-bit assembly register; a 2-bit byte counter wraps 3->0.
    - On the edge accepting the 4th byte, the next cycle asserts wr_en=1 with wr_data=assembled word and wr_addr=word_index<<2.
    - The word index increments on the same edge that deasserts wr_en.
    - After the write of word index target-1, go to DONE.
  - DONE: in_ready=0, cpu_hold=0, done=1. A start pulse behaves as in IDLE, which reloads and reasserts cpu_hold the following cycle.
- Latency: wr_en rises exactly 1 cycle after the 4th byte handshake. Minimum throughput is 5 cycles per word.
- Overflow: bytes beyond the clamped target are not accepted in LOAD. The loader enters DONE after DEPTH words. The upstream stream must then be flushed externally.
- wr_addr wrap-around is impossible: the word index never exceeds DEPTH-1 and its width is clog2(DEPTH)+1.
- Synchronous reset mid-load:
  - Aborts immediately to IDLE with all reset values.
  - Words already written remain in memory.
  - Partial bytes are discarded.
- Simultaneous events:
  - start is ignored while in HEADER or LOAD.
  - reset has priority over everything.
  - in_valid with in_ready=0 is a no-op; the upstream must hold the byte.
- wr_data and wr_addr hold their last values when wr_en=0.

Decomposition:
- Shared package (cpu_pkg), to be reused by the instruction memory's write port:
  - IMEM_DEPTH=128
  - WORD_W=32
  - state encoding constants LD_IDLE=2'd0, LD_HEADER=2'd1, LD_LOAD=2'd2, LD_DONE=2'd3
- One sub-module, byte_assembler:
  - Contains the 4-byte shift register plus the 2-bit counter.
  - Outputs word_ready and word.
  - Reused for both the header and the payload.

Test Plan:
- Reset then start, header 00 00 00 02, bytes 20 08 00 20 / 20 09 00 37 -> wr_en pulses with (addr 0x0, 0x20080020) and (addr 0x4, 0x20090037); done=1, cpu_hold=0 after the second write.
- Header 00 00 00 00 -> DONE directly, no wr_en, done=1.
- Header 00 00 00 C8 (200) -> overflow=1; exactly 128 writes with the last at wr_addr=0x1FC; done=1; in_ready=0 afterwards.
- Bursty in_valid (random gaps 0-3 cycles) across 3 words -> identical wr_data/wr_addr sequence; no byte lost or duplicated; in_ready low exactly on each wr_en cycle.
- reset asserted after 2 payload bytes of word 1 -> next cycle state IDLE, cpu_hold=1, wr_en=0; a fresh start and header reload from address 0.
- start pulses in LOAD are ignored; start in DONE reloads with cpu_hold reasserted and done cleared on the next cycle.
